fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Fetch-stage sequencer for the pipelined core. It drives the enable (`E`) and `next_pc` inputs of the program counter register, and the enable and flush of the IF/ID pipeline register. It arbitrates between sequential fetch (PC + 4), a branch redirect resolved in EX, and a load-use stall from the hazard unit. It also inserts a boot hold after reset and a configurable number of redirect bubbles.

## Interface
- `PC_W`, 8: PC width in bits.
- `PC_STEP`, 4: sequential increment.
- `BOOT_CYCLES`, 2: cycles of PC hold after reset release. Legal range 1..15.
- `FLUSH_CYCLES`, 1: IF/ID flush cycles per redirect, including the redirect cycle. Legal range 1..8.
- `clk`  in  1  clock; all registers on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pc`  in  PC_W  current PC register value.
- `stall`  in  1  load-use stall request from the hazard unit.
- `br_taken`  in  1  branch/jump taken, resolved in EX.
- `br_target`  in  PC_W  redirect address; valid when `br_taken`=1.
- `pc_en`  out  1  to PC `E`.
- `next_pc`  out  PC_W  to PC `next_pc`.
- `if_id_en`  out  1  IF/ID register load enable.
- `if_id_flush`  out  1  IF/ID register clear (inserts a bubble).
- `state`  out  2  current FSM state (debug).

## Operation
- States: BOOT=0, RUN=1, STALL=2, REDIRECT=3.
- Default `next_pc` = (`pc` + PC_STEP) mod 2^PC_W. This wraps, so 0xFC → 0x00.
- BOOT:
  - Outputs: `pc_en`=0, `if_id_en`=0, `if_id_flush`=1.
  - `boot_cnt` counts up each cycle.
  - After BOOT_CYCLES cycles → RUN. Inputs are ignored.
- RUN / STALL share the same decision, evaluated in priority order:
  1. `br_taken`:
     - Outputs: `next_pc`=`br_target`, `pc_en`=1, `if_id_en`=0, `if_id_flush`=1.
     - Next state: if FLUSH_CYCLES>1, load `flush_cnt`=FLUSH_CYCLES-1 → REDIRECT; else → RUN.
  2. `stall`:
     - Outputs: `pc_en`=0, `if_id_en`=0, `if_id_flush`=0.
     - Next state → STALL.
  3. Otherwise:
     - Outputs: `pc_en`=1, `if_id_en`=1, `if_id_flush`=0.
     - Next state → RUN.
- Branch beats stall when both are asserted in the same cycle. The stalled instruction is on the wrong path and is discarded.
- REDIRECT:
  - Outputs: `pc_en`=0 (PC holds at the target), `if_id_en`=0, `if_id_flush`=1.
  - `flush_cnt` decrements each cycle; at 1 → RUN.
  - `stall` and `br_taken` are ignored, because only bubbles are in flight.
- Reset asserted in any state: asynchronous return to BOOT, with `boot_cnt` and `flush_cnt` cleared. No partial redirect survives.
- `pc_en` and `if_id_en` are never both 1 while `if_id_flush`=1.

## Timing
- Outputs are Mealy: combinational from registered state plus `stall`/`br_taken`/`br_target`/`pc`, in the same cycle. No added latency.
- The PC updates at the edge where `pc_en`=1. The redirect target appears on `pc` one cycle after `br_taken`.
- While `reset`=0, outputs are: `state`=BOOT, `pc_en`=0, `if_id_en`=0, `if_id_flush`=1, `next_pc`=`pc`+PC_STEP. Under `FETCH_CTRL_PERF_EN`, counters are also 0.
- First `pc_en`=1 occurs in the (BOOT_CYCLES+1)th cycle after reset deassertion.
- A redirect costs FLUSH_CYCLES bubble cycles in IF/ID.

## Configuration
- Macro `FETCH_CTRL_PERF_EN`. When defined, the block adds these output ports:
  - `stall_cnt` out 16: cycles with `stall` honoured (case 2 above).
  - `redirect_cnt` out 16: redirects accepted.
  - Both counters saturate at 0xFFFF.
  - Both are cleared by reset only.
- Undefined: the ports and counters are absent. The rest of the behaviour is identical.

## Structure
- `fetch_ctrl_pkg`:
  - `fetch_state_t` enum (BOOT/RUN/STALL/REDIRECT with the encodings above).
  - `PC_W`, `PC_STEP` defaults.
  - Counter width constants.
- One sub-module, `pc_incr`: parameterized PC_W-bit `pc + PC_STEP` with wrap. The FSM and counters live in `fetch_ctrl`.

## Test plan
- Reset release with BOOT_CYCLES=2, pc=0x00: `pc_en`=0 for 2 cycles, then 1 → `pc` sequence 0x00, 0x00, 0x00, 0x04, 0x08.
- pc=0xFC in RUN, no stall/branch: `next_pc`=0x00, `pc_en`=1 → pc wraps to 0x00.
- `stall`=1 for 3 cycles at pc=0x10: `pc_en`=0, `if_id_en`=0, `state`=STALL, pc holds 0x10; release → 0x14. `stall_cnt`=3 when perf is enabled.
- `br_taken`=1 and `stall`=1 together, `br_target`=0x40, FLUSH_CYCLES=3: `pc_en`=1, flush=1, then REDIRECT for 2 cycles with pc=0x40 held, flush=1, then RUN → 0x44. `redirect_cnt`=1, `stall_cnt` unchanged.
- `reset`=0 asserted mid-REDIRECT: outputs go to reset values immediately (async), `state`=BOOT. After release, full BOOT_CYCLES hold, no residual flush.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage sequencer.
// Optional build macro FETCH_CTRL_PERF_EN adds the stall/redirect performance counters.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } fetch_state_t;

    localparam int PC_W_DEFAULT    = 8;
    localparam int PC_STEP_DEFAULT = 4;

    // Boot hold tops out at 15 cycles, flush at 8, so 4 bits covers both.
    localparam int BOOT_CNT_W  = 4;
    localparam int FLUSH_CNT_W = 4;
    localparam int PERF_CNT_W  = 16;

    localparam logic [PERF_CNT_W-1:0] PERF_CNT_MAX = '1;

`ifdef FETCH_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (v == PERF_CNT_MAX) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fetch_ctrl_pc_incr.sv
// Sequential next-PC adder; the sum wraps modulo 2^PC_W.
module pc_incr
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W    = PC_W_DEFAULT,
    parameter int PC_STEP = PC_STEP_DEFAULT
) (
    input  logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus
);

    assign pc_plus = pc + PC_W'(PC_STEP);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: arbitrates sequential fetch, branch redirect and load-use stall.
// Build macro FETCH_CTRL_PERF_EN adds stall_cnt / redirect_cnt outputs.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int PC_W         = PC_W_DEFAULT,
    parameter int PC_STEP      = PC_STEP_DEFAULT,
    parameter int BOOT_CYCLES  = 2,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            pc_en,
    output logic [PC_W-1:0] next_pc,
    output logic            if_id_en,
    output logic            if_id_flush,
    output logic [1:0]      state
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] stall_cnt,
    output logic [PERF_CNT_W-1:0] redirect_cnt
`endif
);

    localparam logic [BOOT_CNT_W-1:0]  BOOT_LAST  = BOOT_CNT_W'(BOOT_CYCLES - 1);
    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

    fetch_state_t           cur_state;
    fetch_state_t           nxt_state;
    logic [BOOT_CNT_W-1:0]  boot_cnt;
    logic [BOOT_CNT_W-1:0]  boot_cnt_nxt;
    logic [FLUSH_CNT_W-1:0] flush_cnt;
    logic [FLUSH_CNT_W-1:0] flush_cnt_nxt;
    logic [PC_W-1:0]        pc_plus;

    pc_incr #(
        .PC_W    (PC_W),
        .PC_STEP (PC_STEP)
    ) u_pc_incr (
        .pc      (pc),
        .pc_plus (pc_plus)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_state <= BOOT;
            boot_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            boot_cnt  <= boot_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
        end
    end

    // RUN and STALL share one decision: branch beats stall, stall beats fetch.
    always_comb begin
        nxt_state     = cur_state;
        boot_cnt_nxt  = boot_cnt;
        flush_cnt_nxt = flush_cnt;
        next_pc       = pc_plus;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        if_id_flush   = 1'b0;

        case (cur_state)
            BOOT: begin
                if_id_flush  = 1'b1;
                boot_cnt_nxt = boot_cnt + BOOT_CNT_W'(1);
                if (boot_cnt == BOOT_LAST) begin
                    nxt_state = RUN;
                end
            end

            RUN, STALL: begin
                if (br_taken) begin
                    next_pc     = br_target;
                    pc_en       = 1'b1;
                    if_id_flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        flush_cnt_nxt = FLUSH_LOAD;
                        nxt_state     = REDIRECT;
                    end else begin
                        nxt_state = RUN;
                    end
                end else if (stall) begin
                    nxt_state = STALL;
                end else begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    nxt_state = RUN;
                end
            end

            REDIRECT: begin
                if_id_flush = 1'b1;
                if (flush_cnt <= FLUSH_CNT_W'(1)) begin
                    flush_cnt_nxt = '0;
                    nxt_state     = RUN;
                end else begin
                    flush_cnt_nxt = flush_cnt - FLUSH_CNT_W'(1);
                end
            end

            default: begin
                nxt_state = BOOT;
            end
        endcase
    end

    assign state = cur_state;

`ifdef FETCH_CTRL_PERF_EN
    logic decide_state;
    logic stall_honoured;
    logic redirect_accepted;

    assign decide_state      = (cur_state == RUN) || (cur_state == STALL);
    assign redirect_accepted = decide_state && br_taken;
    assign stall_honoured    = decide_state && stall && !br_taken;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            if (stall_honoured) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (redirect_accepted) begin
                redirect_cnt <= sat_inc(redirect_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl, with a behavioural PC register closing the loop.
module tb_fetch_ctrl;

    localparam logic [1:0] S_BOOT     = 2'd0;
    localparam logic [1:0] S_RUN      = 2'd1;
    localparam logic [1:0] S_STALL    = 2'd2;
    localparam logic [1:0] S_REDIRECT = 2'd3;

    typedef struct {
        string      lbl;
        logic [1:0] st;
        logic       pc_en;
        logic       if_en;
        logic       flush;
        logic [7:0] nxt;
        logic [7:0] pc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic [7:0] pc;
    logic       stall;
    logic       br_taken;
    logic [7:0] br_target;
    logic       pc_en;
    logic [7:0] next_pc;
    logic       if_id_en;
    logic       if_id_flush;
    logic [1:0] state;
`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;
`endif

    logic       load_en;
    logic [7:0] load_val;

    int n_compared;
    int n_mismatched;
    exp_t exp_q[$];

    fetch_ctrl #(
        .PC_W         (8),
        .PC_STEP      (4),
        .BOOT_CYCLES  (2),
        .FLUSH_CYCLES (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .pc_en        (pc_en),
        .next_pc      (next_pc),
        .if_id_en     (if_id_en),
        .if_id_flush  (if_id_flush),
        .state        (state)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .redirect_cnt (redirect_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register model: preload for test setup, otherwise follows E / next_pc.
    always @(posedge clk) begin
        if (load_en) pc <= load_val;
        else if (pc_en) pc <= next_pc;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_compared++;
        if (got !== want) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input string lbl, input logic [1:0] st, input logic pe,
                                input logic ie, input logic fl, input logic [7:0] nx,
                                input logic [7:0] p);
        exp_t e;
        e.lbl = lbl; e.st = st; e.pc_en = pe; e.if_en = ie; e.flush = fl; e.nxt = nx; e.pc = p;
        return e;
    endfunction

    task automatic applyStimulus(input logic s, input logic b, input logic [7:0] tgt, input exp_t e);
        stall     = s;
        br_taken  = b;
        br_target = tgt;
        exp_q.push_back(e);
    endtask

    task automatic sampleAndCompare();
        exp_t e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            checkOutput({e.lbl, ".state"},       32'(state),       32'(e.st));
            checkOutput({e.lbl, ".pc_en"},       32'(pc_en),       32'(e.pc_en));
            checkOutput({e.lbl, ".if_id_en"},    32'(if_id_en),    32'(e.if_en));
            checkOutput({e.lbl, ".if_id_flush"}, 32'(if_id_flush), 32'(e.flush));
            checkOutput({e.lbl, ".next_pc"},     32'(next_pc),     32'(e.nxt));
            checkOutput({e.lbl, ".pc"},          32'(pc),          32'(e.pc));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s, input logic b, input logic [7:0] tgt, input exp_t e);
        applyStimulus(s, b, tgt, e);
        sampleAndCompare();
    endtask

    task automatic loadPc(input logic [7:0] v);
        stall    = 1'b0;
        br_taken = 1'b0;
        load_en  = 1'b1;
        load_val = v;
        @(posedge clk);
        #1;
        load_en = 1'b0;
    endtask

    task automatic checkResetOutputs(input string lbl, input logic [7:0] want_next);
        checkOutput({lbl, ".state"},       32'(state),       32'(S_BOOT));
        checkOutput({lbl, ".pc_en"},       32'(pc_en),       32'd0);
        checkOutput({lbl, ".if_id_en"},    32'(if_id_en),    32'd0);
        checkOutput({lbl, ".if_id_flush"}, 32'(if_id_flush), 32'd1);
        checkOutput({lbl, ".next_pc"},     32'(next_pc),     32'(want_next));
`ifdef FETCH_CTRL_PERF_EN
        checkOutput({lbl, ".stall_cnt"},    32'(stall_cnt),    32'd0);
        checkOutput({lbl, ".redirect_cnt"}, 32'(redirect_cnt), 32'd0);
`endif
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset     = 1'b0;
        stall     = 1'b0;
        br_taken  = 1'b0;
        br_target = 8'h00;
        load_en   = 1'b1;
        load_val  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checkResetOutputs("reset_init", 8'h04);

        reset   = 1'b1;
        load_en = 1'b0;

        // Boot hold then sequential fetch
        step(0, 0, 8'h00, mk("boot1", S_BOOT, 0, 0, 1, 8'h04, 8'h00));
        step(0, 0, 8'h00, mk("boot2", S_BOOT, 0, 0, 1, 8'h04, 8'h00));
        step(0, 0, 8'h00, mk("run1",  S_RUN,  1, 1, 0, 8'h04, 8'h00));
        step(0, 0, 8'h00, mk("run2",  S_RUN,  1, 1, 0, 8'h08, 8'h04));
        step(0, 0, 8'h00, mk("run3",  S_RUN,  1, 1, 0, 8'h0C, 8'h08));

        // PC wrap
        loadPc(8'hFC);
        step(0, 0, 8'h00, mk("wrap1", S_RUN, 1, 1, 0, 8'h00, 8'hFC));
        step(0, 0, 8'h00, mk("wrap2", S_RUN, 1, 1, 0, 8'h04, 8'h00));

        // Three-cycle load-use stall
        loadPc(8'h10);
        step(1, 0, 8'h00, mk("stall1",  S_RUN,   0, 0, 0, 8'h14, 8'h10));
        step(1, 0, 8'h00, mk("stall2",  S_STALL, 0, 0, 0, 8'h14, 8'h10));
        step(1, 0, 8'h00, mk("stall3",  S_STALL, 0, 0, 0, 8'h14, 8'h10));
        step(0, 0, 8'h00, mk("unstall", S_STALL, 1, 1, 0, 8'h14, 8'h10));
        step(0, 0, 8'h00, mk("post_st", S_RUN,   1, 1, 0, 8'h18, 8'h14));
`ifdef FETCH_CTRL_PERF_EN
        checkOutput("perf_stall3", 32'(stall_cnt), 32'd3);
`endif

        // Branch and stall together; REDIRECT ignores further requests
        step(1, 1, 8'h40, mk("br_st",  S_RUN,      1, 0, 1, 8'h40, 8'h18));
        step(1, 1, 8'h80, mk("redir1", S_REDIRECT, 0, 0, 1, 8'h44, 8'h40));
        step(1, 1, 8'h80, mk("redir2", S_REDIRECT, 0, 0, 1, 8'h44, 8'h40));
        step(0, 0, 8'h00, mk("br_run", S_RUN,      1, 1, 0, 8'h44, 8'h40));
        step(0, 0, 8'h00, mk("br_seq", S_RUN,      1, 1, 0, 8'h48, 8'h44));
`ifdef FETCH_CTRL_PERF_EN
        checkOutput("perf_stall_keep", 32'(stall_cnt),    32'd3);
        checkOutput("perf_redir1",     32'(redirect_cnt), 32'd1);
`endif

        // Branch taken out of STALL
        step(1, 0, 8'h00, mk("st_a",   S_RUN,      0, 0, 0, 8'h4C, 8'h48));
        step(0, 1, 8'h20, mk("st_br",  S_STALL,    1, 0, 1, 8'h20, 8'h48));
        step(0, 0, 8'h00, mk("st_rd1", S_REDIRECT, 0, 0, 1, 8'h24, 8'h20));
        step(0, 0, 8'h00, mk("st_rd2", S_REDIRECT, 0, 0, 1, 8'h24, 8'h20));
        step(0, 0, 8'h00, mk("st_run", S_RUN,      1, 1, 0, 8'h24, 8'h20));
`ifdef FETCH_CTRL_PERF_EN
        checkOutput("perf_stall4", 32'(stall_cnt),    32'd4);
        checkOutput("perf_redir2", 32'(redirect_cnt), 32'd2);
`endif

        // Reset asserted in the middle of REDIRECT
        step(0, 1, 8'h60, mk("rb_br",  S_RUN,      1, 0, 1, 8'h60, 8'h24));
        step(0, 0, 8'h00, mk("rb_rd1", S_REDIRECT, 0, 0, 1, 8'h64, 8'h60));
        reset = 1'b0;
        #1;
        checkResetOutputs("reset_mid", 8'h64);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, 8'h00, mk("rboot1", S_BOOT, 0, 0, 1, 8'h64, 8'h60));
        step(0, 0, 8'h00, mk("rboot2", S_BOOT, 0, 0, 1, 8'h64, 8'h60));
        step(0, 0, 8'h00, mk("rrun1",  S_RUN,  1, 1, 0, 8'h64, 8'h60));
        step(0, 0, 8'h00, mk("rrun2",  S_RUN,  1, 1, 0, 8'h68, 8'h64));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
